// File: rtl/registrador_instrucoes_multipalavra_pkg.sv
// Shared definitions for the multi-word instruction register.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package registrador_instrucoes_multipalavra_pkg;

    // Default geometry matches the classic SAP-1 8-bit W-bus.
    localparam int DEF_WORD_W = 8;
    localparam int DEF_OPC_W  = 4;

    // All-zero extension mask at the default opcode width: every opcode is one word.
    localparam logic [2**DEF_OPC_W-1:0] DEF_EXT_MASK = {2**DEF_OPC_W{1'b0}};

    // Fetch state. 2'b11 is unused and recovers to ST_EMPTY.
    typedef enum logic [1:0] {
        ST_EMPTY    = 2'b00,
        ST_WAIT_EXT = 2'b01,
        ST_READY    = 2'b10
    } ir_state_t;

endpackage

// File: rtl/ci244_octaBuffer_tristate.sv
// Octal tristate line driver, two 4-bit halves with active-low enables (74x244 style).
// Latency: combinational.
// Backpressure: none; outputs float to Z when the half is disabled.
//
// Ports:
//   a      8-bit data in
//   oe1_n  active-low enable for y[3:0]
//   oe2_n  active-low enable for y[7:4]
//   y      8-bit tristate data out
module ci244_octaBuffer_tristate (
    input  logic [7:0] a,
    input  logic       oe1_n,
    input  logic       oe2_n,
    output wire  [7:0] y
);

    assign y[3:0] = oe1_n ? 4'bzzzz : a[3:0];
    assign y[7:4] = oe2_n ? 4'bzzzz : a[7:4];

endmodule

// File: rtl/registrador_instrucoes_multipalavra.sv
// Instruction register: splits bus words into opcode/operand, masked opcodes fetch a full-width extension word.
// Latency: 1 load cycle to ir_valid for one-word opcodes, 2 load cycles for extended opcodes.
// Backpressure: none; IR_IN is always accepted, IR_CLR wins over IR_IN, IR_IN low holds everything.
//
// Ports:
//   clock, clear_n      rising-edge clock, async active-low reset
//   IR_CLR              synchronous flush to EMPTY (drops a simultaneous IR_IN word)
//   IR_IN, bus_in       load strobe and W-bus data
//   IR_OUT, bus_out     drive operand onto the W-bus, Z otherwise
//   opcode_out          held opcode
//   operand_out         held operand, always driven
//   ir_valid            complete instruction held
//   ir_wait_ext         first word of a two-word instruction held, extension pending
module registrador_instrucoes_multipalavra
    import registrador_instrucoes_multipalavra_pkg::*;
#(
    parameter int                    WORD_W   = DEF_WORD_W,
    parameter int                    OPC_W    = DEF_OPC_W,
    parameter logic [2**OPC_W-1:0]   EXT_MASK = '0
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic              IR_CLR,
    input  logic              IR_IN,
    input  logic              IR_OUT,
    input  logic [WORD_W-1:0] bus_in,
    output wire  [WORD_W-1:0] bus_out,
    output logic [OPC_W-1:0]  opcode_out,
    output logic [WORD_W-1:0] operand_out,
    output logic              ir_valid,
    output logic              ir_wait_ext
);

    // Width of the short operand field that follows the opcode in a first word.
    localparam int SHORT_W = WORD_W - OPC_W;
    localparam int N_OCT   = WORD_W / 8;
    localparam int REM_W   = WORD_W % 8;

    ir_state_t           state_q, state_d;
    logic [OPC_W-1:0]    opcode_q, opcode_d;
    logic [WORD_W-1:0]   operand_q, operand_d;
    logic [OPC_W-1:0]    word_opc;
    logic [WORD_W-1:0]   word_short;

    assign word_opc   = bus_in[WORD_W-1 -: OPC_W];
    assign word_short = {{OPC_W{1'b0}}, bus_in[SHORT_W-1:0]};

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q   <= ST_EMPTY;
            opcode_q  <= '0;
            operand_q <= '0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        if (IR_CLR) begin
            state_d   = ST_EMPTY;
            opcode_d  = '0;
            operand_d = '0;
        end else begin
            case (state_q)
                // A new first word may replace a held instruction with no bubble.
                ST_EMPTY, ST_READY: begin
                    if (IR_IN) begin
                        opcode_d  = word_opc;
                        operand_d = word_short;
                        state_d   = EXT_MASK[word_opc] ? ST_WAIT_EXT : ST_READY;
                    end
                end
                ST_WAIT_EXT: begin
                    if (IR_IN) begin
                        operand_d = bus_in;
                        state_d   = ST_READY;
                    end
                end
                // Unused encoding: drop whatever is held and start clean.
                default: begin
                    state_d   = ST_EMPTY;
                    opcode_d  = '0;
                    operand_d = '0;
                end
            endcase
        end
    end

    assign opcode_out  = opcode_q;
    assign operand_out = operand_q;
    assign ir_valid    = (state_q == ST_READY);
    assign ir_wait_ext = (state_q == ST_WAIT_EXT);

    // Bus driver: whole octets through the '244 part, any leftover bits with a plain tristate.
    genvar g;
    for (g = 0; g < N_OCT; g++) begin : g_oct
        ci244_octaBuffer_tristate u_buf (
            .a     (operand_q[8*g +: 8]),
            .oe1_n (~IR_OUT),
            .oe2_n (~IR_OUT),
            .y     (bus_out[8*g +: 8])
        );
    end

    if (REM_W > 0) begin : g_rem
        assign bus_out[WORD_W-1 -: REM_W] = IR_OUT ? operand_q[WORD_W-1 -: REM_W] : {REM_W{1'bz}};
    end

endmodule

// File: tb/tb_registrador_instrucoes_multipalavra.sv
// Bench for the multi-word instruction register: directed cases plus randomized traffic against a field-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_registrador_instrucoes_multipalavra;

    logic        clock = 1'b0;
    logic        clear_n = 1'b0;

    // 8-bit instance, opcode 6 is two-word
    logic        ir_clr = 1'b0, ir_in = 1'b0, ir_out = 1'b0;
    logic [7:0]  bus_in = '0;
    wire  [7:0]  bus8;
    logic [3:0]  opc8;
    logic [7:0]  opr8;
    logic        vld8, wx8;

    // 12-bit instance, no extended opcodes
    logic        ir_clr12 = 1'b0, ir_in12 = 1'b0, ir_out12 = 1'b0;
    logic [11:0] bus_in12 = '0;
    wire  [11:0] bus12;
    logic [3:0]  opc12;
    logic [11:0] opr12;
    logic        vld12, wx12;

    // Bench-side driver on the 8-bit bus: shows through only when the DUT has released it.
    logic [7:0]  probe_val = 8'h5A;
    assign bus8 = ir_out ? 8'bzzzz_zzzz : probe_val;

    int total = 0;
    int bad   = 0;

    // Field-level model of the 8-bit instance
    logic [3:0]  m_opc;
    logic [7:0]  m_opr;
    logic        m_pending, m_valid;

    // Model of the 12-bit instance
    logic [3:0]  m12_opc;
    logic [11:0] m12_opr;
    logic        m12_valid;

    registrador_instrucoes_multipalavra #(
        .WORD_W(8), .OPC_W(4), .EXT_MASK(16'h0040)
    ) dut8 (
        .clock(clock), .clear_n(clear_n), .IR_CLR(ir_clr), .IR_IN(ir_in), .IR_OUT(ir_out),
        .bus_in(bus_in), .bus_out(bus8), .opcode_out(opc8), .operand_out(opr8),
        .ir_valid(vld8), .ir_wait_ext(wx8)
    );

    registrador_instrucoes_multipalavra #(
        .WORD_W(12), .OPC_W(4), .EXT_MASK(16'h0000)
    ) dut12 (
        .clock(clock), .clear_n(clear_n), .IR_CLR(ir_clr12), .IR_IN(ir_in12), .IR_OUT(ir_out12),
        .bus_in(bus_in12), .bus_out(bus12), .opcode_out(opc12), .operand_out(opr12),
        .ir_valid(vld12), .ir_wait_ext(wx12)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check8(input string tag, input logic [3:0] opc, input logic [7:0] opr,
                          input logic vld, input logic wx);
        check_eq({tag, "_opc"}, 32'(opc8), 32'(opc));
        check_eq({tag, "_opr"}, 32'(opr8), 32'(opr));
        check_eq({tag, "_vld"}, 32'(vld8), 32'(vld));
        check_eq({tag, "_wx"},  32'(wx8),  32'(wx));
    endtask

    // One clock of the 8-bit instance in instruction terms.
    task automatic model_apply(input logic clr, input logic ld, input logic [7:0] w);
        if (clr) begin
            m_opc = 4'h0; m_opr = 8'h00; m_pending = 1'b0; m_valid = 1'b0;
        end else if (ld) begin
            if (m_pending) begin
                m_opr = w; m_pending = 1'b0; m_valid = 1'b1;
            end else begin
                m_opc     = w / 16;
                m_opr     = w % 16;
                m_pending = (m_opc == 4'd6);
                m_valid   = !m_pending;
            end
        end
    endtask

    logic       r_clr, r_in, r_out;
    logic [7:0] r_w;
    logic [11:0] r_w12;

    initial begin
        // Reset state
        #2;
        check8("reset", 4'h0, 8'h00, 1'b0, 1'b0);
        check_eq("reset_bus_z", 32'(bus8), 32'h5A);

        // 1: one-word load
        ir_in = 1'b1; bus_in = 8'h1E;
        #1 clear_n = 1'b1;
        tick();
        check8("t1_load", 4'h1, 8'h0E, 1'b1, 1'b0);
        ir_in = 1'b0; ir_out = 1'b1;
        #1 check_eq("t1_bus_drv", 32'(bus8), 32'h0E);
        ir_out = 1'b0; probe_val = 8'h5A;
        #1 check_eq("t1_bus_z", 32'(bus8), 32'h5A);

        // 2: two-word load
        ir_in = 1'b1; bus_in = 8'h63;
        tick();
        check8("t2_first", 4'h6, 8'h03, 1'b0, 1'b1);
        ir_out = 1'b1;
        #1 check_eq("t2_bus_short", 32'(bus8), 32'h03);
        ir_out = 1'b0; bus_in = 8'hA5;
        tick();
        check8("t2_ext", 4'h6, 8'hA5, 1'b1, 1'b0);

        // 3: flush beats a simultaneous load in WAIT_EXT
        bus_in = 8'h63;
        tick();
        check8("t3_wait", 4'h6, 8'h03, 1'b0, 1'b1);
        ir_clr = 1'b1; bus_in = 8'hFF;
        tick();
        check8("t3_flush", 4'h0, 8'h00, 1'b0, 1'b0);
        ir_clr = 1'b0;

        // 4: async reset between edges in WAIT_EXT
        bus_in = 8'h63;
        tick();
        ir_in = 1'b0;
        #2 clear_n = 1'b0;
        #1 check8("t4_async", 4'h0, 8'h00, 1'b0, 1'b0);
        clear_n = 1'b1;
        ir_in = 1'b1; bus_in = 8'h2C;
        tick();
        check8("t4_first", 4'h2, 8'h0C, 1'b1, 1'b0);

        // 5: overwrite READY with an extended opcode, then hold
        bus_in = 8'h1E;
        tick();
        bus_in = 8'h67;
        tick();
        check8("t5_over", 4'h6, 8'h07, 1'b0, 1'b1);
        ir_in = 1'b0; bus_in = 8'hC3;
        for (int i = 0; i < 3; i++) begin
            tick();
            check8("t5_hold", 4'h6, 8'h07, 1'b0, 1'b1);
        end

        // 6: 12-bit instance, no extended opcodes
        ir_in12 = 1'b1; bus_in12 = 12'hF3A;
        tick();
        ir_in12 = 1'b0;
        check_eq("t6_opc", 32'(opc12), 32'hF);
        check_eq("t6_opr", 32'(opr12), 32'h03A);
        check_eq("t6_vld", 32'(vld12), 32'h1);
        check_eq("t6_wx",  32'(wx12),  32'h0);
        ir_out12 = 1'b1;
        #1 check_eq("t6_bus", 32'(bus12), 32'h03A);
        ir_out12 = 1'b0;

        // Randomized traffic on the 8-bit instance
        #2 clear_n = 1'b0;
        m_opc = 4'h0; m_opr = 8'h00; m_pending = 1'b0; m_valid = 1'b0;
        m12_opc = 4'h0; m12_opr = 12'h000; m12_valid = 1'b0;
        #1 clear_n = 1'b1;
        tick();
        for (int i = 0; i < 400; i++) begin
            r_clr = ($urandom_range(0, 15) == 0);
            r_in  = 1'($urandom_range(0, 1));
            r_out = 1'($urandom_range(0, 1));
            r_w   = ($urandom_range(0, 3) == 0) ? {4'h6, 4'($urandom)} : 8'($urandom);
            ir_clr = r_clr; ir_in = r_in; ir_out = r_out; bus_in = r_w;
            probe_val = 8'($urandom);
            #1;
            if (r_out) check_eq("rnd_bus_drv", 32'(bus8), 32'(m_opr));
            else       check_eq("rnd_bus_z",   32'(bus8), 32'(probe_val));
            tick();
            model_apply(r_clr, r_in, r_w);
            check8("rnd", m_opc, m_opr, m_valid, m_pending);
        end
        ir_clr = 1'b0; ir_in = 1'b0; ir_out = 1'b0;

        // Randomized traffic on the 12-bit instance
        for (int i = 0; i < 100; i++) begin
            r_clr = ($urandom_range(0, 15) == 0);
            r_in  = 1'($urandom_range(0, 1));
            r_w12 = 12'($urandom);
            ir_clr12 = r_clr; ir_in12 = r_in; bus_in12 = r_w12;
            tick();
            if (r_clr) begin
                m12_opc = 4'h0; m12_opr = 12'h000; m12_valid = 1'b0;
            end else if (r_in) begin
                m12_opc = r_w12 / 256; m12_opr = r_w12 % 256; m12_valid = 1'b1;
            end
            check_eq("r12_opc", 32'(opc12), 32'(m12_opc));
            check_eq("r12_opr", 32'(opr12), 32'(m12_opr));
            check_eq("r12_vld", 32'(vld12), 32'(m12_valid));
            check_eq("r12_wx",  32'(wx12),  32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/registrador_instrucoes_multipalavra.md
Name: registrador_instrucoes_multipalavra

Overview:
Parametrised successor to the SAP-1 instruction register. Splits each fetched word into opcode and short operand fields. Opcodes flagged in a mask fetch one extra bus word as a full-width operand. Sits between the W-bus and the controller/sequencer: it presents opcode, operand and fetch status to the controller and drives the operand onto the bus on request.

Parameters:
WORD_W, 8, bus and operand word width in bits (>= OPC_W+1).
OPC_W, 4, opcode field width in bits, taken from the word MSBs.
EXT_MASK, {2**OPC_W{1'b0}}, bit k=1 marks opcode k as a two-word instruction. The all-zero default gives SAP-1 behaviour.

Ports:
clock  input  1  system clock, rising edge.
clear_n  input  1  asynchronous active-low reset.
IR_CLR  input  1  synchronous flush; abandons any fetch in progress.
IR_IN  input  1  load enable; captures bus_in on the rising edge.
IR_OUT  input  1  drives the operand onto bus_out.
bus_in  input  WORD_W  W-bus data in.
bus_out  output  WORD_W  tristate operand out; Z when IR_OUT=0.
opcode_out  output  OPC_W  current opcode to the controller.
operand_out  output  WORD_W  current operand, always driven.
ir_valid  output  1  complete instruction held.
ir_wait_ext  output  1  awaiting the extension word.

Behaviour:
- Clock and reset: single clock domain. clear_n low forces immediately: state EMPTY, opcode_out=0, operand_out=0, ir_valid=0, ir_wait_ext=0, bus_out=Z.
- States:
  - EMPTY: no instruction held.
  - WAIT_EXT: first word of a two-word instruction taken; extension word pending.
  - READY: full instruction held.
- Encoding: EMPTY=2'b00, WAIT_EXT=2'b01, READY=2'b10. 2'b11 is illegal and recovers to EMPTY on the next edge.
- First word (IR_IN=1 in EMPTY or READY):
  - opcode register <= bus_in[WORD_W-1 -: OPC_W].
  - operand register <= zero-extended bus_in[WORD_W-OPC_W-1:0].
  - If EXT_MASK[opcode]=1, go to WAIT_EXT; otherwise go to READY.
  - Loading in READY overwrites the held instruction. No bubble: ir_valid stays 1 into the next READY, or drops to 0 if the new opcode is extended.
- Extension word (IR_IN=1 in WAIT_EXT): operand register <= bus_in in full; opcode unchanged; go to READY.
- IR_IN=0: hold all registers and state.
- IR_CLR=1: state <= EMPTY, opcode and operand <= 0. IR_CLR has priority over a simultaneous IR_IN, so that word is discarded.
- Outputs are registered and reflect the state after the edge:
  - ir_valid = (state==READY).
  - ir_wait_ext = (state==WAIT_EXT).
  - Latency: bus word to valid output is 1 cycle for a one-word instruction and 2 load cycles for a two-word instruction.
- bus_out: combinational, = operand_out when IR_OUT=1, else all Z. It is not gated by state; IR_OUT in WAIT_EXT drives the zero-extended short field.
- IR_IN and IR_OUT may both be high; bus_out then shows the pre-edge operand. The controller must never assert both in the same T-state on a shared bus; the block does not check this.
- Reset mid-fetch (clear_n low in WAIT_EXT) discards the partial instruction. The next IR_IN word is treated as a first word.

Decomposition:
- Shared include (sap_defs.vh): state encodings, default WORD_W and OPC_W, and the default-width constant for an all-zero EXT_MASK.
- Sub-module: reuse the existing ci244_octaBuffer_tristate for the bus_out driver, replicated or generated for WORD_W > 8.
- All register and FSM logic stays inline; no new sub-module.

Test Plan:
Bench configuration unless noted: WORD_W=8, OPC_W=4, EXT_MASK=16'h0040 (opcode 6 is two-word).
1. Reset and one-word load: clear_n pulse, then IR_IN with bus_in=8'h1E -> opcode_out=4'h1, operand_out=8'h0E, ir_valid=1 after one edge; IR_OUT=1 gives bus_out=8'h0E; IR_OUT=0 gives bus_out=Z.
2. Two-word load: bus_in=8'h63 with IR_IN -> ir_wait_ext=1, ir_valid=0, operand_out=8'h03; then bus_in=8'hA5 with IR_IN -> ir_valid=1, opcode_out=4'h6, operand_out=8'hA5.
3. Flush: in WAIT_EXT after 8'h63, assert IR_CLR and IR_IN (bus_in=8'hFF) together -> EMPTY, opcode_out=0, operand_out=0, both flags 0.
4. Async reset mid-fetch: drop clear_n between clock edges in WAIT_EXT -> outputs zero without a clock edge; next load 8'h2C is treated as a first word (opcode 2, operand 8'h0C, ir_valid=1).
5. Back-to-back overwrite: READY holding 8'h1E, load 8'h67 -> ir_valid falls to 0, ir_wait_ext=1; hold IR_IN low 3 cycles -> state and outputs unchanged.
6. Parameter sweep: WORD_W=12, OPC_W=4, EXT_MASK=0, load 12'hF3A -> opcode 4'hF, operand 12'h03A, ir_valid=1; no state ever reaches WAIT_EXT.
